// File: rtl/fb_pkg.sv
// Shared types, default geometry and helpers for the frame-buffer writer.
package fb_pkg;

    localparam int          HDISP_DFLT       = 800;
    localparam int          VDISP_DFLT       = 480;
    localparam int          BURSTSIZE_DFLT   = 16;
    localparam int          DEPTH_WIDTH_DFLT = 5;
    localparam logic [31:0] BASE_ADDR_DFLT   = 32'h0;

    localparam int FRAME_WORDS = HDISP_DFLT * VDISP_DFLT;
    localparam int FRAME_BYTES = 4 * FRAME_WORDS;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wr_state_t;

    // One 32-bit SDRAM word per pixel, upper byte unused.
    function automatic logic [31:0] pack_pixel(input logic [23:0] rgb);
        return {8'h00, rgb};
    endfunction

endpackage

// File: rtl/fb_writer_if.sv
// Pixel stream and Avalon-MM write bus bundles for the frame-buffer writer.
interface pix_stream_if;
    logic        pix_valid;
    logic        pix_sof;
    logic [23:0] pix_data;
    logic        pix_ready;

    modport master (output pix_valid, output pix_sof, output pix_data, input  pix_ready);
    modport slave  (input  pix_valid, input  pix_sof, input  pix_data, output pix_ready);
endinterface

interface avm_wr_if;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [5:0]  avm_burstcount;
    logic        avm_waitrequest;

    modport master (output avm_address, output avm_write, output avm_writedata,
                    output avm_byteenable, output avm_burstcount, input avm_waitrequest);
    modport slave  (input  avm_address, input  avm_write, input  avm_writedata,
                    input  avm_byteenable, input  avm_burstcount, output avm_waitrequest);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rdata always presents the head entry.
module sync_fifo #(
    parameter int DATA_WIDTH  = 24,
    parameter int DEPTH_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic                   pop,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic [DEPTH_WIDTH:0]   count,
    output logic                   full,
    output logic                   empty
);

    localparam logic [DEPTH_WIDTH:0] DEPTH = (DEPTH_WIDTH+1)'(2**DEPTH_WIDTH);

    logic [DATA_WIDTH-1:0]  mem [2**DEPTH_WIDTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic                   wr_en;
    logic                   rd_en;

    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Pixel stream to SDRAM frame buffer: buffers pixels and emits fixed-length Avalon write bursts.
//   state | meaning
//   IDLE  | waiting for a full burst of pixels in the FIFO
//   BURST | avm_write high, one FIFO word per accepted beat
module fb_writer import fb_pkg::*; #(
    parameter int          HDISP       = HDISP_DFLT,
    parameter int          VDISP       = VDISP_DFLT,
    parameter int          BURSTSIZE   = BURSTSIZE_DFLT,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DFLT,
    parameter int          DEPTH_WIDTH = DEPTH_WIDTH_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    pix_stream_if.slave pix,
    avm_wr_if.master    avm,
    output logic        frame_done,
    output logic        sof_err
);

    localparam int          FRAME_W     = HDISP * VDISP;
    localparam int          CNT_W       = $clog2(FRAME_W);
    localparam int          BEAT_W      = $clog2(BURSTSIZE + 1);
    localparam logic [31:0] BURST_BYTES = 32'(4 * BURSTSIZE);
    localparam logic [31:0] WRAP_ADDR   = BASE_ADDR + 32'(4 * FRAME_W);

    wr_state_t              state_q, state_d;
    logic                   synced;
    logic                   ready;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   wr_en;
    logic                   load_beats;
    logic                   last_beat;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DEPTH_WIDTH:0]   fifo_count;
    logic [23:0]            fifo_rdata;
    logic [CNT_W-1:0]       pix_cnt;
    logic [BEAT_W-1:0]      beats_left;
    logic [31:0]            addr_q;

    // Unsynchronised pixels are swallowed, so ready only throttles once synced.
    assign ready         = !synced || !fifo_full;
    assign pix.pix_ready = ready;
    assign accept        = pix.pix_valid && ready;
    assign push          = accept && (synced || pix.pix_sof);
    assign wr_en         = (state_q == BURST);
    assign pop           = wr_en && !avm.avm_waitrequest && !fifo_empty;

    assign avm.avm_write      = wr_en;
    assign avm.avm_address    = addr_q;
    assign avm.avm_writedata  = pack_pixel(fifo_rdata);
    assign avm.avm_byteenable = 4'hf;
    assign avm.avm_burstcount = 6'(BURSTSIZE);

    sync_fifo #(
        .DATA_WIDTH  (24),
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (pix.pix_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synced  <= 1'b0;
            sof_err <= 1'b0;
            pix_cnt <= '0;
        end else begin
            if (accept && pix.pix_sof) begin
                synced <= 1'b1;
                // Misplaced SOF is flagged only; the counter keeps its linear position.
                if (synced && pix_cnt != '0) sof_err <= 1'b1;
            end
            if (push) begin
                pix_cnt <= (pix_cnt == CNT_W'(FRAME_W - 1)) ? '0 : pix_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_beats = 1'b0;
        last_beat  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_count >= (DEPTH_WIDTH+1)'(BURSTSIZE)) begin
                    state_d    = BURST;
                    load_beats = 1'b1;
                end
            end
            BURST: begin
                if (pop && beats_left == '0) begin
                    state_d   = IDLE;
                    last_beat = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_left <= '0;
            addr_q     <= BASE_ADDR;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (load_beats)             beats_left <= BEAT_W'(BURSTSIZE - 1);
            else if (pop && !last_beat) beats_left <= beats_left - 1'b1;
            if (last_beat) begin
                if (addr_q + BURST_BYTES == WRAP_ADDR) begin
                    addr_q     <= BASE_ADDR;
                    frame_done <= 1'b1;
                end else begin
                    addr_q <= addr_q + BURST_BYTES;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer on a reduced 16x4 frame (4 bursts of 16 words per frame).
module tb_fb_writer;

    localparam int          HD   = 16;
    localparam int          VD   = 4;
    localparam int          BS   = 16;
    localparam int          FW   = HD * VD;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] FB   = 32'(4 * FW);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_done;
    logic sof_err;

    pix_stream_if pix_bus ();
    avm_wr_if     avm_bus ();

    fb_writer #(
        .HDISP       (HD),
        .VDISP       (VD),
        .BURSTSIZE   (BS),
        .BASE_ADDR   (BASE),
        .DEPTH_WIDTH (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix        (pix_bus),
        .avm        (avm_bus),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_q[$];
    bit          tb_synced   = 1'b0;
    int          tb_cnt      = 0;
    bit          exp_sof_err = 1'b0;
    logic [31:0] exp_addr    = BASE;
    logic [31:0] last_addr   = 32'hffff_ffff;
    int          beats       = 0;
    bit          fd_pending  = 1'b0;
    bit          expect_low  = 1'b0;
    int          n_fd        = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [23:0] d, input bit sof);
        int guard = 0;
        pix_bus.pix_valid = 1'b1;
        pix_bus.pix_data  = d;
        pix_bus.pix_sof   = sof;
        @(negedge clk);
        while (pix_bus.pix_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("pix_ready_timeout", 32'(pix_bus.pix_ready), 32'd1);
        if (pix_bus.pix_ready === 1'b1) begin
            if (tb_synced && sof && tb_cnt != 0) exp_sof_err = 1'b1;
            if (tb_synced || sof) begin
                tb_synced = 1'b1;
                exp_q.push_back({8'h00, d});
                tb_cnt = (tb_cnt == FW - 1) ? 0 : tb_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
        pix_bus.pix_valid = 1'b0;
        pix_bus.pix_sof   = 1'b0;
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send(24'($urandom), 1'b0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || avm_bus.avm_write === 1'b1) && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        tb_synced   = 1'b0;
        tb_cnt      = 0;
        exp_sof_err = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every beat is compared against the oldest pushed pixel.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_addr   = BASE;
            beats      = 0;
            fd_pending = 1'b0;
            expect_low = 1'b0;
        end else begin
            check("frame_done", 32'(frame_done), 32'(fd_pending));
            if (frame_done === 1'b1) n_fd++;
            fd_pending = 1'b0;
            if (expect_low) begin
                check("write_drop", 32'(avm_bus.avm_write), 32'd0);
                expect_low = 1'b0;
            end else if (avm_bus.avm_write === 1'b1) begin
                check("address", avm_bus.avm_address, exp_addr);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $error("FAIL extra_beat: observed data %h expected none", avm_bus.avm_writedata);
                end else begin
                    check("writedata", avm_bus.avm_writedata, exp_q[0]);
                end
                if (avm_bus.avm_waitrequest === 1'b0) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    beats++;
                    if (beats == BS) begin
                        last_addr = exp_addr;
                        if (exp_addr + 32'(4 * BS) == BASE + FB) begin
                            exp_addr   = BASE;
                            fd_pending = 1'b1;
                        end else begin
                            exp_addr = exp_addr + 32'(4 * BS);
                        end
                        beats      = 0;
                        expect_low = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_bus.pix_valid = 1'b0;
        pix_bus.pix_sof   = 1'b0;
        pix_bus.pix_data  = '0;
        avm_bus.avm_waitrequest = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_write",      32'(avm_bus.avm_write), 32'd0);
        check("rst_address",    avm_bus.avm_address, BASE);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_sof_err",    32'(sof_err), 32'd0);
        check("rst_pix_ready",  32'(pix_bus.pix_ready), 32'd1);
        check("byteenable",     32'(avm_bus.avm_byteenable), 32'h0000_000f);
        check("burstcount",     32'(avm_bus.avm_burstcount), 32'd16);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One burst, SOF on the first pixel; write rises one cycle after the 16th push.
        send(24'h123456, 1'b1);
        send_n(15);
        @(negedge clk);
        check("burst_start_early", 32'(avm_bus.avm_write), 32'd0);
        @(negedge clk);
        check("burst_start", 32'(avm_bus.avm_write), 32'd1);
        drain();
        check("no_frame_done_yet", 32'(n_fd), 32'd0);

        // Pre-SOF pixels are discarded.
        apply_reset();
        send_n(20);
        repeat (5) @(posedge clk);
        #1;
        check("unsynced_no_write", 32'(avm_bus.avm_write), 32'd0);
        send(24'hABCDEF, 1'b1);
        send_n(15);
        drain();

        // Remaining 48 pixels of frame 1: last burst at 0xC0, then wrap.
        send_n(48);
        drain();
        check("frame1_done_count", 32'(n_fd), 32'd1);
        check("frame1_last_addr",  last_addr, 32'h0000_00C0);
        check("frame1_sof_err",    32'(sof_err), 32'd0);

        // Frame 2 with a 50-cycle stall on the first burst while pixels keep streaming.
        fork
            begin
                send(24'($urandom), 1'b1);
                send_n(63);
            end
            begin
                int guard = 0;
                while (avm_bus.avm_write !== 1'b1 && guard < 2000) begin
                    @(posedge clk);
                    #1;
                    guard++;
                end
                check("stall_burst_seen", 32'(avm_bus.avm_write), 32'd1);
                repeat (3) @(posedge clk);
                #1;
                avm_bus.avm_waitrequest = 1'b1;
                repeat (50) @(posedge clk);
                #1;
                check("stall_pix_ready", 32'(pix_bus.pix_ready), 32'd0);
                check("stall_fifo_level", 32'(exp_q.size()), 32'd32);
                check("stall_write_held", 32'(avm_bus.avm_write), 32'd1);
                avm_bus.avm_waitrequest = 1'b0;
            end
        join
        drain();
        check("frame2_done_count", 32'(n_fd), 32'd2);
        check("frame2_sof_err",    32'(sof_err), 32'd0);

        // Frame 3: SOF arrives at pixel index 40, flagged but not realigned.
        send_n(40);
        send(24'h0F0F0F, 1'b1);
        send_n(23);
        drain();
        check("sof_err_model", 32'(sof_err), 32'(exp_sof_err));
        check("sof_err_set",   32'(sof_err), 32'd1);
        check("frame3_done_count", 32'(n_fd), 32'd3);

        // Reset while beat 7 of a burst is in flight.
        send_n(16);
        begin
            int guard = 0;
            while (beats != 7 && guard < 2000) begin
                @(posedge clk);
                #1;
                guard++;
            end
        end
        check("mid_beats_reached", 32'(beats), 32'd7);
        check("sof_err_sticky",    32'(sof_err), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_write",     32'(avm_bus.avm_write), 32'd0);
        check("midrst_address",   avm_bus.avm_address, BASE);
        check("midrst_pix_ready", 32'(pix_bus.pix_ready), 32'd1);
        check("midrst_sof_err",   32'(sof_err), 32'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        tb_synced   = 1'b0;
        tb_cnt      = 0;
        exp_sof_err = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // After reset: unsynced again and FIFO empty, so only the new SOF burst appears.
        send_n(5);
        repeat (3) @(posedge clk);
        #1;
        check("postrst_no_write", 32'(avm_bus.avm_write), 32'd0);
        send(24'h55AA33, 1'b1);
        send_n(15);
        drain();
        check("postrst_last_addr", last_addr, BASE);
        check("postrst_sof_err",   32'(sof_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
